// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable register, byte-capture handshake FSM and a
// first-word-fall-through receive FIFO. Optional macro: UART_RX_FERR_DROP_EN.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_wr,
    input  logic [1:0]    cfg_wdata,
    output logic          SPEN,
    output logic          RXEN,
    input  logic          rx_rxif,
    input  logic          rx_ferr,
    input  logic [7:0]    rx_data,
    output logic          rx_read_en,
    input  logic          cpu_rd,
    output logic [7:0]    cpu_rdata,
    output logic          rx_valid,
    output logic [CW-1:0] fifo_count,
    output logic          ovf,
    output logic          ferr_sticky,
    input  logic          clr_err,
    output logic          irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_CLR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_spen;
    logic          r_rxen;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_ferr;

    logic w_capture;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_ovf_set;
    logic w_ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spen <= 1'b0;
            r_rxen <= 1'b0;
        end else if (cfg_wr) begin
            r_spen <= cfg_wdata[0];
            r_rxen <= cfg_wdata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // WAIT_CLR holds until the receiver drops its flag so one byte is taken once
    always_comb begin
        w_state_nxt = r_state;
        rx_read_en  = 1'b0;
        case (r_state)
            IDLE:     if (rx_rxif && r_rxen) w_state_nxt = CAPTURE;
            CAPTURE: begin
                rx_read_en  = 1'b1;
                w_state_nxt = WAIT_CLR;
            end
            WAIT_CLR: if (!rx_rxif) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign w_capture  = (r_state == CAPTURE);
    assign w_ferr_set = w_capture & rx_ferr;
`ifdef UART_RX_FERR_DROP_EN
    assign w_push     = w_capture & ~rx_ferr;
`else
    assign w_push     = w_capture;
`endif

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = cpu_rd & ~w_empty;
    // When full, a simultaneous pop frees the head slot, which is where wr_ptr points
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr && !rst) r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set events take priority over clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
            if (w_ferr_set)   r_ferr <= 1'b1;
            else if (clr_err) r_ferr <= 1'b0;
        end
    end

    assign SPEN        = r_spen;
    assign RXEN        = r_rxen;
    assign rx_valid    = ~w_empty;
    assign cpu_rdata   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign ovf         = r_ovf;
    assign ferr_sticky = r_ferr;
    assign irq         = ~w_empty | r_ovf | r_ferr;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default 3, meaning width of fifo_count (log2(FIFO_DEPTH)+1).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: cfg_wr  input  1  write strobe for the enable register.
REQ-007 Port: cfg_wdata  input  2  bit0 SPEN, bit1 RXEN.
REQ-008 Port: SPEN  output  1  serial port enable to receiver.
REQ-009 Port: RXEN  output  1  receive enable to receiver.
REQ-010 Port: rx_rxif  input  1  receiver byte-ready flag.
REQ-011 Port: rx_ferr  input  1  receiver framing-error flag.
REQ-012 Port: rx_data  input  8  receiver data bus.
REQ-013 Port: rx_read_en  output  1  read/acknowledge strobe to receiver.
REQ-014 Port: cpu_rd  input  1  pop request for FIFO head.
REQ-015 Port: cpu_rdata  output  8  FIFO head (first-word fall-through).
REQ-016 Port: rx_valid  output  1  FIFO non-empty.
REQ-017 Port: fifo_count  output  CW  entries held.
REQ-018 Port: ovf  output  1  sticky overrun flag.
REQ-019 Port: ferr_sticky  output  1  sticky framing-error flag.
REQ-020 Port: clr_err  input  1  clears ovf and ferr_sticky.
REQ-021 Port: irq  output  1  rx_valid OR ovf OR ferr_sticky.

Function
REQ-022 cfg_wr SHALL load SPEN/RXEN from cfg_wdata on the next edge.
REQ-023 FSM states SHALL be IDLE, CAPTURE, WAIT_CLR.
REQ-024 IDLE->CAPTURE when rx_rxif=1 and RXEN=1; otherwise remain IDLE.
REQ-025 In CAPTURE, rx_read_en SHALL be 1 for exactly that one cycle; rx_data/rx_ferr sampled on the exiting edge; CAPTURE->WAIT_CLR unconditionally.
REQ-026 WAIT_CLR->IDLE when rx_rxif=0; otherwise remain (no second capture of same byte).
REQ-027 rx_read_en SHALL be 0 in all states except CAPTURE.
REQ-028 Clearing RXEN SHALL block new IDLE->CAPTURE transitions; an in-progress CAPTURE/WAIT_CLR completes.
REQ-029 Captured byte SHALL be visible on cpu_rdata/rx_valid the cycle after CAPTURE if FIFO was empty.
REQ-030 cpu_rd with rx_valid=1 SHALL pop head on the edge; cpu_rd with FIFO empty SHALL be ignored.
REQ-031 Push when full and no simultaneous pop: byte discarded, ovf set.
REQ-032 Simultaneous push and pop (any fill level, incl. full): both occur, count unchanged, ovf unchanged.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count range 0..FIFO_DEPTH.
REQ-034 Captured rx_ferr=1 SHALL set ferr_sticky.
REQ-035 clr_err SHALL clear ovf and ferr_sticky; a same-cycle set event wins over clr_err.
REQ-036 cpu_rdata SHALL be 8'h00 when FIFO empty.

Reset
REQ-037 rst SHALL force: state IDLE, SPEN=0, RXEN=0, rx_read_en=0, pointers/fifo_count=0, rx_valid=0, cpu_rdata=8'h00, ovf=0, ferr_sticky=0, irq=0.
REQ-038 rst asserted mid-CAPTURE/WAIT_CLR SHALL abort without pushing; rst has priority over all inputs.

Configuration
REQ-039 Macro UART_RX_FERR_DROP_EN defined: bytes captured with rx_ferr=1 SHALL NOT be pushed (ferr_sticky still set, rx_read_en still pulsed).
REQ-040 Macro undefined: bytes with rx_ferr=1 SHALL be pushed like any other byte.

Verification
REQ-041 rst, cfg 2'b11, rx_rxif=1 rx_data=8'hA5 -> rx_read_en one cycle, next cycle rx_valid=1 cpu_rdata=8'hA5 fifo_count=1.
REQ-042 5 bytes 8'h01..8'h05, no cpu_rd, depth 4 -> fifo_count=4, ovf=1, pops return 01,02,03,04.
REQ-043 FIFO full, push 8'h77 with cpu_rd same cycle -> ovf=0, count=4, tail=8'h77.
REQ-044 rx_rxif held 1 for 10 cycles -> exactly one rx_read_en pulse, one push.
REQ-045 rx_ferr=1 with byte 8'h3C -> ferr_sticky=1, irq=1; count +1 without macro, +0 with UART_RX_FERR_DROP_EN.
REQ-046 rst during WAIT_CLR with 2 entries -> next cycle count=0, rx_valid=0, SPEN=RXEN=0, state IDLE.
